// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default
// latency and the byte-lane merge used by the storage array.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned CNT_W               = 4;

    // Replace only the byte lanes selected by be; other lanes keep old_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_responder_store.sv
// Word storage for the responder: combinational read of the addressed word,
// byte-lane merge, and a synchronous write of the merged word.
module mem_responder_store
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic [31:0]      merged_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Read is asynchronous so the top can sample it on the same edge it writes.
    assign rdata_o  = mem_q[idx_i];
    assign merged_o = merge_bytes(rdata_o, wdata_i, be_i);

    // Every word clears on reset; writes store the already-merged word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= merged_o;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed wait-state count.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | req_ready high, waiting for req_valid
//   WAIT    | request latched, down-counter running toward the response
//   RESP    | response presented, held until resp_ready
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned      IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] WAIT_LD     = CNT_W'(WAIT_CYCLES);
    localparam logic [32:0]      LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, err_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q, pc_q;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic             accept, enter_resp, commit;
    logic [32:0]      diff;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;
    logic             cur_we, cur_err;
    logic [IDX_W-1:0] cur_idx;
    logic [3:0]       cur_be;
    logic [31:0]      cur_wdata, cur_pc;
    logic [31:0]      store_rdata, store_merged;

    // Borrow out of the 33-bit subtraction means the address is below the window.
    assign diff    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign req_err = diff[32] || ({1'b0, diff[31:0]} >= LIMIT_BYTES) || (req_be == 4'b0000);
    assign req_idx = diff[IDX_W+1:2];

    assign accept = req_valid && (state_q == ST_IDLE);

    // With zero wait states the response is built on the accepting edge,
    // before anything is latched, so the live request is used in IDLE.
    assign cur_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign cur_err   = (state_q == ST_IDLE) ? req_err   : err_q;
    assign cur_idx   = (state_q == ST_IDLE) ? req_idx   : idx_q;
    assign cur_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign cur_pc    = (state_q == ST_IDLE) ? req_pc    : pc_q;

    assign commit = enter_resp && cur_we && !cur_err;

    // Next-state, wait counter and response data.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        enter_resp   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_LD == '0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (enter_resp) begin
            resp_rdata_d = (cur_we || cur_err) ? 32'h0 : store_rdata;
            resp_err_d   = cur_err;
        end
    end

    // State, counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Request fields captured on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            err_q   <= req_err;
            idx_q   <= req_idx;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
        end
    end

    mem_responder_store #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_store (
        .clk      (clk),
        .rst      (reset),
        .we_i     (commit),
        .idx_i    (cur_idx),
        .be_i     (cur_be),
        .wdata_i  (cur_wdata),
        .rdata_o  (store_rdata),
        .merged_o (store_merged)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

`ifndef SYNTHESIS
    // Write log: issuing PC, word-aligned address, full word after merge.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            $display("@%h: *%h <= %h", cur_pc, BASE_ADDR + (32'(cur_idx) << 2), store_merged);
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int          W     = 2;
    localparam int          DEPTH = 1024;
    localparam int          ZDEP  = 16;
    localparam logic [31:0] ZBASE = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, req_pc, resp_rdata;
    logic [3:0]  req_be;
    logic        z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_req_pc, z_resp_rdata;
    logic [3:0]  z_req_be;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] z_mem [ZDEP];

    mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.DEPTH_WORDS(ZDEP), .BASE_ADDR(ZBASE), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_be(z_req_be), .req_wdata(z_req_wdata), .req_pc(z_req_pc),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] addr, input logic [3:0] be,
                                     input longint base, input longint depth);
        longint off;
        off = longint'(addr) - base;
        return (be == 4'b0) || (off < 0) || ((off / 4) >= depth);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    // One transaction on the WAIT_CYCLES=2 responder; entered and left #1 after a rising edge.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input int bp, input string tag,
                       output logic [31:0] rd, output logic er);
        bit          e;
        int          idx;
        int          edges;
        logic [31:0] exp_rd;
        e      = model_err(addr, be, 0, DEPTH);
        idx    = int'(addr >> 2);
        exp_rd = (we || e) ? 32'h0 : model_mem[idx];
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be;
        req_wdata = wdata; req_pc = $urandom;
        @(posedge clk); #1;
        // A competing store is presented while busy; it must not be taken.
        req_we = 1'b1; req_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
        req_be = 4'hF; req_wdata = $urandom;
        edges = 0;
        while (resp_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        req_valid = 1'b0;
        chk({tag, ".latency"}, 32'(edges), 32'(W));
        chk({tag, ".err"},     32'(resp_err), 32'(e));
        chk({tag, ".rdata"},   resp_rdata, exp_rd);
        rd = resp_rdata;
        er = resp_err;
        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            chk({tag, ".bp_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ".bp_rdata"}, resp_rdata, exp_rd);
            chk({tag, ".bp_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, ".done_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, ".done_ready"}, 32'(req_ready), 32'd1);
        if (we && !e) model_mem[idx] = model_merge(model_mem[idx], wdata, be);
    endtask

    // One transaction on the zero-wait responder with resp_ready held high.
    task automatic ztxn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input string tag);
        bit          e;
        int          idx;
        logic [31:0] exp_rd;
        e      = model_err(addr, be, longint'(ZBASE), ZDEP);
        idx    = int'((addr - ZBASE) >> 2);
        exp_rd = (we || e) ? 32'h0 : z_mem[idx];
        chk({tag, ".req_ready"}, 32'(z_req_ready), 32'd1);
        z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_be = be;
        z_req_wdata = wdata; z_req_pc = $urandom;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        chk({tag, ".valid"},  32'(z_resp_valid), 32'd1);
        chk({tag, ".busy"},   32'(z_req_ready), 32'd0);
        chk({tag, ".err"},    32'(z_resp_err), 32'(e));
        chk({tag, ".rdata"},  z_resp_rdata, exp_rd);
        @(posedge clk); #1;
        chk({tag, ".idle_ready"}, 32'(z_req_ready), 32'd1);
        chk({tag, ".idle_valid"}, 32'(z_resp_valid), 32'd0);
        if (we && !e) z_mem[idx] = model_merge(z_mem[idx], wdata, be);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; req_pc = '0;
        resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_be = '0;
        z_req_wdata = '0; z_req_pc = '0; z_resp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        for (int i = 0; i < ZDEP; i++)  z_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst.req_ready",  32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.resp_err",   32'(resp_err), 32'd0);

        // Store then load.
        txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, "st10", rd, er);
        chk("st10.err_const", 32'(er), 32'd0);
        txn(1'b0, 32'h10, 4'hF, 32'h0, 0, "ld10", rd, er);
        chk("ld10.const", rd, 32'hDEADBEEF);

        // Partial store.
        txn(1'b1, 32'h20, 4'hF, 32'h11223344, 0, "st20", rd, er);
        txn(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 0, "st20p", rd, er);
        txn(1'b0, 32'h22, 4'b0001, 32'h0, 0, "ld20", rd, er);
        chk("ld20.const", rd, 32'h11BB33DD);

        // Out of range and zero byte-enable.
        txn(1'b0, 32'h1000, 4'hF, 32'h0, 0, "oor", rd, er);
        chk("oor.err_const", 32'(er), 32'd1);
        chk("oor.rdata_const", rd, 32'h0);
        txn(1'b1, 32'h10, 4'h0, 32'h12345678, 0, "be0", rd, er);
        chk("be0.err_const", 32'(er), 32'd1);
        txn(1'b0, 32'h10, 4'hF, 32'h0, 0, "be0_ld", rd, er);
        chk("be0_ld.const", rd, 32'hDEADBEEF);

        // Back-pressure.
        txn(1'b0, 32'h20, 4'hF, 32'h0, 5, "bp", rd, er);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) addr = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            else                          addr = 32'h1000 + 32'($urandom_range(0, 16'hFFFF));
            be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            txn(we, addr, be, $urandom, int'($urandom_range(0, 3)), "rnd", rd, er);
        end

        // Reset while a store to 0x30 is waiting.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_be = 4'hF;
        req_wdata = 32'hCAFEF00D; req_pc = 32'h400;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstw.in_wait", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rstw.async_ready", 32'(req_ready), 32'd1);
        chk("rstw.async_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        for (int i = 0; i < ZDEP; i++)  z_mem[i] = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rstw.no_resp", 32'(resp_valid), 32'd0);
        end
        chk("rstw.ready", 32'(req_ready), 32'd1);
        txn(1'b0, 32'h30, 4'hF, 32'h0, 0, "rstw_ld", rd, er);
        chk("rstw_ld.const", rd, 32'h0);

        // Zero wait states, non-zero base, small depth.
        ztxn(1'b1, 32'h104, 4'hF, 32'h0BADF00D, "z_st");
        ztxn(1'b0, 32'h104, 4'hF, 32'h0, "z_ld");
        ztxn(1'b1, 32'h13C, 4'b1100, 32'h5566_7788, "z_st_top");
        ztxn(1'b0, 32'h13C, 4'hF, 32'h0, "z_ld_top");
        ztxn(1'b0, 32'h080, 4'hF, 32'h0, "z_below");
        ztxn(1'b0, 32'h140, 4'hF, 32'h0, "z_above");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
